addsub_occupancy_accumulator: RTL and testbench

Registered, parametrised add/subtract accumulator that holds the current parking-lot occupancy count. Each accepted request adds or subtracts an operand using two's-complement addition with an inverted operand and carry-in equal to op_sub. The result is bounded to 0..CAPACITY by either saturation or rejection. A valid/ready handshake sits on both sides. It sits between the entry/exit gate sensors and the display/controller logic.

---
 rtl/addsub_occupancy_accumulator.sv | 104 ++++++++++
 tb/tb_addsub_occupancy_accumulator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/addsub_occupancy_accumulator.sv
// Registered add/subtract occupancy counter bounded to 0..CAPACITY, with
// valid/ready handshakes, a load override and sticky range-error flags.
module addsub_occupancy_accumulator #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CAPACITY = 200,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] operand,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clr_err,
    output logic [WIDTH-1:0] count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             full,
    output logic             empty,
    output logic             overflow_err,
    output logic             underflow_err,
    output logic             reject
);

    localparam logic [WIDTH-1:0] CAP_N = WIDTH'(CAPACITY);
    localparam logic [WIDTH:0]   CAP_W = (WIDTH+1)'(CAPACITY);

    logic [WIDTH-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             reject_q, reject_d;

    logic             accept;
    logic [WIDTH:0]   sum;
    logic             add_oor;
    logic             sub_oor;

    assign in_ready = !load && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Subtract is count + ~operand + 1; bit WIDTH clear means a borrow occurred.
    assign sum     = {1'b0, count_q} + {1'b0, operand ^ {WIDTH{op_sub}}} + {{WIDTH{1'b0}}, op_sub};
    assign add_oor = !op_sub && (sum > CAP_W);
    assign sub_oor = op_sub && !sum[WIDTH];

    always_comb begin
        count_d     = count_q;
        out_valid_d = out_valid_q && !out_ready;
        ovf_d       = ovf_q && !clr_err;
        unf_d       = unf_q && !clr_err;
        reject_d    = 1'b0;

        if (load) begin
            out_valid_d = 1'b1;
            if ({1'b0, load_value} > CAP_W) begin
                count_d = CAP_N;
                ovf_d   = 1'b1;
            end else begin
                count_d = load_value;
            end
        end else if (accept) begin
            out_valid_d = 1'b1;
            if (add_oor) begin
                ovf_d = 1'b1;
                if (SATURATE) count_d  = CAP_N;
                else          reject_d = 1'b1;
            end else if (sub_oor) begin
                unf_d = 1'b1;
                if (SATURATE) count_d  = '0;
                else          reject_d = 1'b1;
            end else begin
                count_d = sum[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            reject_q    <= reject_d;
        end
    end

    assign count         = count_q;
    assign out_valid     = out_valid_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
    assign reject        = reject_q;
    assign full          = (count_q == CAP_N);
    assign empty         = (count_q == '0);

endmodule

// File: tb/tb_addsub_occupancy_accumulator.sv
// Drives a saturating and a rejecting instance with shared stimulus and
// checks both against an integer-arithmetic occupancy model.
module tb_addsub_occupancy_accumulator;

    localparam int CAP = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       op_sub = 1'b0;
    logic [7:0] operand = '0;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;
    logic       clr_err = 1'b0;
    logic       out_ready = 1'b0;

    logic       d_in_ready [2];
    logic [7:0] d_count    [2];
    logic       d_out_valid[2];
    logic       d_full     [2];
    logic       d_empty    [2];
    logic       d_ovf      [2];
    logic       d_unf      [2];
    logic       d_reject   [2];

    int m_cnt[2];
    int m_ov [2];
    int m_of [2];
    int m_uf [2];
    int m_rj [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    addsub_occupancy_accumulator #(.WIDTH(8), .CAPACITY(CAP), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready[0]),
        .op_sub(op_sub), .operand(operand), .load(load), .load_value(load_value),
        .clr_err(clr_err), .count(d_count[0]), .out_valid(d_out_valid[0]),
        .out_ready(out_ready), .full(d_full[0]), .empty(d_empty[0]),
        .overflow_err(d_ovf[0]), .underflow_err(d_unf[0]), .reject(d_reject[0])
    );

    addsub_occupancy_accumulator #(.WIDTH(8), .CAPACITY(CAP), .SATURATE(1'b0)) u_rej (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready[1]),
        .op_sub(op_sub), .operand(operand), .load(load), .load_value(load_value),
        .clr_err(clr_err), .count(d_count[1]), .out_valid(d_out_valid[1]),
        .out_ready(out_ready), .full(d_full[1]), .empty(d_empty[1]),
        .overflow_err(d_ovf[1]), .underflow_err(d_unf[1]), .reject(d_reject[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check ready, advance the model, check outputs.
    task automatic cyc(input logic r, input logic iv, input logic sub, input int opnd,
                       input logic ld, input int lv, input logic clr, input logic ordy);
        int rdy[2];
        rst = r; in_valid = iv; op_sub = sub; operand = 8'(opnd);
        load = ld; load_value = 8'(lv); clr_err = clr; out_ready = ordy;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            rdy[k] = (!ld && (m_ov[k] == 0 || ordy)) ? 1 : 0;
            chk(k == 0 ? "sat_in_ready" : "rej_in_ready", 32'(d_in_ready[k]), 32'(rdy[k]));
        end
        for (int k = 0; k < 2; k++) begin
            int res;
            int nof;
            int nuf;
            nof = 0; nuf = 0;
            if (r) begin
                m_cnt[k] = 0; m_ov[k] = 0; m_of[k] = 0; m_uf[k] = 0; m_rj[k] = 0;
            end else begin
                m_rj[k] = 0;
                if (ld) begin
                    m_cnt[k] = (lv > CAP) ? CAP : lv;
                    nof = (lv > CAP) ? 1 : 0;
                    m_ov[k] = 1;
                end else if (iv && rdy[k] != 0) begin
                    res = sub ? m_cnt[k] - opnd : m_cnt[k] + opnd;
                    if (res > CAP) begin
                        nof = 1;
                        if (k == 0) m_cnt[k] = CAP; else m_rj[k] = 1;
                    end else if (res < 0) begin
                        nuf = 1;
                        if (k == 0) m_cnt[k] = 0; else m_rj[k] = 1;
                    end else begin
                        m_cnt[k] = res;
                    end
                    m_ov[k] = 1;
                end else if (ordy) begin
                    m_ov[k] = 0;
                end
                m_of[k] = ((m_of[k] != 0 && !clr) || nof != 0) ? 1 : 0;
                m_uf[k] = ((m_uf[k] != 0 && !clr) || nuf != 0) ? 1 : 0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            string p;
            p = (k == 0) ? "sat_" : "rej_";
            chk({p, "count"},     32'(d_count[k]),     32'(m_cnt[k]));
            chk({p, "out_valid"}, 32'(d_out_valid[k]), 32'(m_ov[k]));
            chk({p, "full"},      32'(d_full[k]),      32'(m_cnt[k] == CAP));
            chk({p, "empty"},     32'(d_empty[k]),     32'(m_cnt[k] == 0));
            chk({p, "overflow"},  32'(d_ovf[k]),       32'(m_of[k]));
            chk({p, "underflow"}, 32'(d_unf[k]),       32'(m_uf[k]));
            chk({p, "reject"},    32'(d_reject[k]),    32'(m_rj[k]));
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_ov[k] = 0; m_of[k] = 0; m_uf[k] = 0; m_rj[k] = 0;
        end
        @(posedge clk);
        #1;

        // reset state and two adds
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        chk("reset_empty", 32'(d_empty[0]), 32'd1);
        cyc(0, 1, 0, 5, 0, 0, 0, 1);
        chk("add5_count", 32'(d_count[0]), 32'd5);
        cyc(0, 1, 0, 3, 0, 0, 0, 1);
        chk("add3_count", 32'(d_count[0]), 32'd8);

        // load near the top, overflow by add, then clear
        cyc(0, 0, 0, 0, 1, 198, 0, 1);
        cyc(0, 1, 0, 5, 0, 0, 0, 1);
        chk("sat_clamp", 32'(d_count[0]), 32'd200);
        chk("rej_hold", 32'(d_count[1]), 32'd198);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("clr_ovf", 32'(d_ovf[0]), 32'd0);

        // underflow, reject pulse width, exact drain to zero
        cyc(0, 0, 0, 0, 1, 3, 0, 1);
        cyc(0, 1, 1, 4, 0, 0, 0, 1);
        chk("rej_sub_hold", 32'(d_count[1]), 32'd3);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rej_pulse_end", 32'(d_reject[1]), 32'd0);
        cyc(0, 1, 1, 3, 0, 0, 0, 1);
        chk("rej_drain_empty", 32'(d_empty[1]), 32'd1);
        cyc(0, 1, 1, 0, 0, 0, 1, 1);

        // backpressure
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0);
        chk("stall_count", 32'(d_count[0]), 32'd1);
        cyc(0, 1, 0, 1, 0, 0, 0, 1);
        chk("unstall_count", 32'(d_count[0]), 32'd2);

        // load beats a simultaneous request
        cyc(0, 1, 0, 1, 1, 250, 0, 1);
        chk("load_cap", 32'(d_count[1]), 32'd200);

        // reset while a result is pending
        cyc(0, 0, 0, 0, 1, 50, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_count", 32'(d_count[0]), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            int r_sel;
            int opnd;
            r_sel = int'($urandom_range(0, 99));
            opnd  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 12));
            cyc(r_sel == 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1,
                opnd,
                r_sel > 93,
                int'($urandom_range(0, 255)),
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
